// File: rtl/checkpoint_seq_monitor_if.sv
// Checkpoint monitor bus: firmware-driven checkbits, programmed signature list,
// timeout budget and start pulse in; status, failing index and elapsed cycles out.
interface checkpoint_seq_monitor_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_CHK = 4,
  parameter int CNT_W   = 24
);
  localparam int IW = $clog2(NUM_CHK + 1);

  logic [WIDTH-1:0]         checkbits_i;
  logic [NUM_CHK*WIDTH-1:0] chk_vals_i;
  logic [CNT_W-1:0]         timeout_cycles_i;
  logic                     start_i;
  logic                     busy_o;
  logic                     pass_o;
  logic                     fail_o;
  logic [1:0]               fail_code_o;
  logic [IW-1:0]            chk_idx_o;
  logic [CNT_W-1:0]         cycles_o;

  // Stimulus / firmware side
  modport master (
    output checkbits_i, chk_vals_i, timeout_cycles_i, start_i,
    input  busy_o, pass_o, fail_o, fail_code_o, chk_idx_o, cycles_o
  );

  // Monitor side
  modport slave (
    input  checkbits_i, chk_vals_i, timeout_cycles_i, start_i,
    output busy_o, pass_o, fail_o, fail_code_o, chk_idx_o, cycles_o
  );
endinterface

// File: rtl/checkpoint_seq_monitor.sv
// Checkpoint sequence monitor: synchronises and glitch-filters a checkbits bus,
// then checks that NUM_CHK programmed signatures appear in order within a budget.

// One comparator lane: does the filtered bus equal this checkpoint's signature.
module checkpoint_seq_monitor_cmp #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic [WIDTH-1:0] i_ref,
  output logic             o_hit
);
  assign o_hit = (i_val == i_ref);
endmodule

module checkpoint_seq_monitor #(
  parameter int WIDTH      = 16,
  parameter int NUM_CHK    = 4,
  parameter int STABLE_CYC = 4,
  parameter int CNT_W      = 24
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_i,
  checkpoint_seq_monitor_if.slave   bus
);
  localparam int IW = $clog2(NUM_CHK + 1);
  localparam int SW = $clog2(STABLE_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_PASS  = 2'd2,
    S_FAIL  = 2'd3
  } state_t;

  // Input path
  logic [WIDTH-1:0]   r_sync1;
  logic [WIDTH-1:0]   r_cb_s;
  logic [SW-1:0]      r_stab;
  logic               r_evt;
  logic               w_same;

  // Sequence state
  state_t             r_state,  w_state_nxt;
  logic [IW-1:0]      r_idx,    w_idx_nxt;
  logic [CNT_W-1:0]   r_cycles, w_cycles_nxt;
  logic               r_pass,   w_pass_nxt;
  logic               r_fail,   w_fail_nxt;
  logic [1:0]         r_code,   w_code_nxt;

  // Checkpoint match vector and its view relative to the expected index
  logic [NUM_CHK-1:0] w_hit;
  logic               w_cur;
  logic               w_ahead;
  logic               w_tmo;

  // The synchronised sample will keep its value across the coming edge
  assign w_same = (r_sync1 == r_cb_s);

  // Two-flop synchroniser plus stability counter; event pulses once per stable value
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_sync1 <= '0;
      r_cb_s  <= '0;
      r_stab  <= '0;
      r_evt   <= 1'b0;
    end else begin
      r_sync1 <= bus.checkbits_i;
      r_cb_s  <= r_sync1;
      // Arming discards stability history so a value already on the bus
      // must be re-observed for a full window before it counts.
      if (bus.start_i || !w_same) begin
        r_stab <= '0;
        r_evt  <= 1'b0;
      end else if (r_stab != SW'(STABLE_CYC)) begin
        r_stab <= r_stab + 1'b1;
        r_evt  <= (r_stab == SW'(STABLE_CYC - 1));
      end else begin
        r_evt  <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_CHK; k++) begin : g_lane
    checkpoint_seq_monitor_cmp #(.WIDTH(WIDTH)) u_cmp (
      .i_val (r_cb_s),
      .i_ref (bus.chk_vals_i[k*WIDTH +: WIDTH]),
      .o_hit (w_hit[k])
    );
  end

  // Split matches into "the expected checkpoint" and "a later checkpoint"
  always_comb begin
    w_cur   = 1'b0;
    w_ahead = 1'b0;
    for (int k = 0; k < NUM_CHK; k++) begin
      if (k == int'(r_idx)) w_cur   = w_cur   | w_hit[k];
      if (k >  int'(r_idx)) w_ahead = w_ahead | w_hit[k];
    end
  end

  assign w_tmo = (bus.timeout_cycles_i != '0) && (r_cycles == bus.timeout_cycles_i);

  // Sequence state register
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= S_IDLE;
      r_idx    <= '0;
      r_cycles <= '0;
      r_pass   <= 1'b0;
      r_fail   <= 1'b0;
      r_code   <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_idx    <= w_idx_nxt;
      r_cycles <= w_cycles_nxt;
      r_pass   <= w_pass_nxt;
      r_fail   <= w_fail_nxt;
      r_code   <= w_code_nxt;
    end
  end

  // Next-state: start re-arms from anywhere; in ARMED a match beats order
  // violation, which beats timeout; the counter only advances on quiet cycles.
  always_comb begin
    w_state_nxt  = r_state;
    w_idx_nxt    = r_idx;
    w_cycles_nxt = r_cycles;
    w_pass_nxt   = r_pass;
    w_fail_nxt   = r_fail;
    w_code_nxt   = r_code;
    if (bus.start_i) begin
      w_state_nxt  = S_ARMED;
      w_idx_nxt    = '0;
      w_cycles_nxt = '0;
      w_pass_nxt   = 1'b0;
      w_fail_nxt   = 1'b0;
      w_code_nxt   = 2'd0;
    end else begin
      case (r_state)
        S_ARMED: begin
          if (r_evt && w_cur) begin
            w_idx_nxt = r_idx + 1'b1;
            if (r_idx == IW'(NUM_CHK - 1)) begin
              w_state_nxt = S_PASS;
              w_pass_nxt  = 1'b1;
            end
          end else if (r_evt && w_ahead) begin
            w_state_nxt = S_FAIL;
            w_fail_nxt  = 1'b1;
            w_code_nxt  = 2'd2;
          end else if (w_tmo) begin
            w_state_nxt = S_FAIL;
            w_fail_nxt  = 1'b1;
            w_code_nxt  = 2'd1;
          end else if (r_cycles != '1) begin
            w_cycles_nxt = r_cycles + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy_o      = (r_state == S_ARMED);
  assign bus.pass_o      = r_pass;
  assign bus.fail_o      = r_fail;
  assign bus.fail_code_o = r_code;
  assign bus.chk_idx_o   = r_idx;
  assign bus.cycles_o    = r_cycles;
endmodule
